// File: rtl/fifo_rd_sched_pkg.sv
// Shared types and helpers for the FIFO read scheduler.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: scheduler state enum, qid width helper, round-robin pick function.
package fifo_rd_sched_pkg;

    // Upper bound on queues the round-robin helper can scan.
    localparam int RR_MAX_Q = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Queue-id width; a single queue still gets a 1-bit id.
    function automatic int qid_width(input int num_q);
        return (num_q > 1) ? $clog2(num_q) : 1;
    endfunction

    // First requesting queue scanning upward from (last + 1) mod num_q.
    // Returns -1 when nothing requests. Scanning k downward and overwriting
    // leaves the smallest k, i.e. the nearest queue after 'last'.
    function automatic int rr_next(input logic [RR_MAX_Q-1:0] req,
                                   input int num_q,
                                   input int last);
        int pick;
        int idx;
        pick = -1;
        for (int k = RR_MAX_Q; k >= 1; k--) begin
            if (k <= num_q) begin
                idx = last + k;
                if (idx >= num_q) begin
                    idx = idx - num_q;
                end
                if (req[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_rd_sched_obuf.sv
// Two-entry FIFO-ordered output buffer holding {qid, last, data} words.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: none internally; the caller must never push into a full buffer without popping.
// Ports: push/push_dat write an entry; pop removes the head; occ, head_vld, head_dat describe the contents.
module fifo_rd_sched_obuf #(
    parameter int DW = 67
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic          head_vld,
    output logic [DW-1:0] head_dat
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    occ_q, occ_d;
    logic          pop_en;

    assign pop_en = pop && (occ_q != 2'd0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_en) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop_en})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ      = occ_q;
    assign head_vld = (occ_q != 2'd0);
    assign head_dat = mem_q[rd_ptr_q];

    // The issue rule in the scheduler guarantees room; catch any regression.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop_en && (occ_q == 2'd2)));

endmodule

// File: rtl/fifo_rd_scheduler.sv
// Round-robin read scheduler sharing one consumer among NUM_Q FIFO read ports, bursting up to BURST words per grant.
// Latency: rden in cycle t gives out_valid/out_data in t+2 with an empty buffer; one word per cycle sustained.
// Backpressure: rden is issued only while buffer + in-flight - pop < 2, so out_ready=0 stalls reads after 2 words.
// Ports: clk/reset; enable gates new grants; q_rdempty/q_rdusedw/q_dataout/q_rden connect the FIFOs;
//        out_data/out_qid/out_last/out_valid/out_ready form the downstream stream; busy flags activity.
module fifo_rd_scheduler
    import fifo_rd_sched_pkg::*;
#(
    parameter int NUM_Q = 4,
    parameter int WIDTH = 64,
    parameter int PTR   = 4,
    parameter int BURST = 8,
    localparam int QW   = qid_width(NUM_Q)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_Q-1:0]         q_rdempty,
    input  logic [NUM_Q*(PTR+1)-1:0] q_rdusedw,
    input  logic [NUM_Q*WIDTH-1:0]   q_dataout,
    output logic [NUM_Q-1:0]         q_rden,
    output logic [WIDTH-1:0]         out_data,
    output logic [QW-1:0]            out_qid,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int PW = PTR + 1;
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int DW = QW + 1 + WIDTH;

    state_e          state_q, state_d;
    // grant_q doubles as the round-robin pointer (last granted queue).
    logic [QW-1:0]   grant_q, grant_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            inflight_q, inflight_d;
    logic            inflight_last_q, inflight_last_d;

    logic            sel_empty;
    logic [PW-1:0]   sel_usedw;
    logic [WIDTH-1:0] sel_data;
    logic [RR_MAX_Q-1:0] req;
    int              pick;

    logic [1:0]      occ;
    logic            head_vld;
    logic [DW-1:0]   head_dat;
    logic            push;
    logic            pop;
    logic [DW-1:0]   push_dat;
    logic            room;
    logic            word_last;
    logic            issue;

    // Mux the granted queue's status and data.
    always_comb begin
        sel_empty = 1'b1;
        sel_usedw = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (grant_q == QW'(i)) begin
                sel_empty = q_rdempty[i];
                sel_usedw = q_rdusedw[i*PW +: PW];
                sel_data  = q_dataout[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req               = '0;
        req[NUM_Q-1:0]    = ~q_rdempty;
        pick              = rr_next(req, NUM_Q, int'(grant_q));
    end

    assign pop = head_vld && out_ready;
    // Words already committed (buffered + in flight), less this cycle's pop, must leave a free slot.
    assign room = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        burst_cnt_d     = burst_cnt_q;
        issue           = 1'b0;
        word_last       = (burst_cnt_q == BW'(BURST - 1)) || (sel_usedw == PW'(1));
        case (state_q)
            ST_IDLE: begin
                if (enable && (pick >= 0)) begin
                    grant_d     = QW'(pick);
                    burst_cnt_d = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!sel_empty && room) begin
                    issue       = 1'b1;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (word_last) begin
                        state_d = ST_DRAIN;
                    end
                end else if (sel_empty) begin
                    // Queue ran dry early: the burst ends without a flagged last word.
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        inflight_d      = issue;
        inflight_last_d = issue && word_last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            grant_q         <= QW'(NUM_Q - 1);
            burst_cnt_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            burst_cnt_q     <= burst_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    always_comb begin
        q_rden = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (issue && (grant_q == QW'(i))) begin
                q_rden[i] = 1'b1;
            end
        end
    end

    // dataout lags rden by one cycle; grant_q is stable until the in-flight word lands.
    assign push     = inflight_q;
    assign push_dat = {grant_q, inflight_last_q, sel_data};

    fifo_rd_sched_obuf #(
        .DW (DW)
    ) u_obuf (
        .clk      (clk),
        .rst      (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .occ      (occ),
        .head_vld (head_vld),
        .head_dat (head_dat)
    );

    assign out_valid = head_vld;
    assign out_qid   = head_dat[DW-1 -: QW];
    assign out_last  = head_dat[WIDTH];
    assign out_data  = head_dat[WIDTH-1:0];
    assign busy      = (state_q != ST_IDLE) || head_vld;

endmodule
